// File: rtl/decode_ctrl_pipe_if.sv
// Handshake and control-bundle signals between IF/ID, the ID-stage decoder and EX.
// The decoder takes the slave view; the upstream/downstream environment takes the master view.
interface decode_ctrl_pipe_if #(
  parameter int ALU_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ALU_W-1:0] alu_ctrl;
  logic             regwrite;
  logic             memtoreg;
  logic             alusrc;
  logic             memread;
  logic             memwrite;
  logic             branch;
  logic             branch_ne;
  logic             jump;
  logic             m_op;
  logic             sys;
  logic             illegal;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;

  modport master (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, alu_ctrl, regwrite, memtoreg, alusrc, memread,
           memwrite, branch, branch_ne, jump, m_op, sys, illegal, rd, rs1, rs2, funct3
  );

  modport slave (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, alu_ctrl, regwrite, memtoreg, alusrc, memread,
           memwrite, branch, branch_ne, jump, m_op, sys, illegal, rd, rs1, rs2, funct3
  );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// Registered RV32IM ID-stage control decoder with a one-entry valid/ready output
// register, multi-cycle MUL/DIV occupancy, flush and illegal-instruction flagging.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | may accept; output register empty or holding a deliverable bundle
//   HOLD  | M op accepted, bundle registered but withheld while cnt_q runs out
module decode_ctrl_pipe #(
  parameter int ALU_W      = 4,
  parameter int M_EN       = 1,
  parameter int MUL_CYCLES = 0,
  parameter int DIV_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  decode_ctrl_pipe_if.slave bus
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'((MUL_CYCLES > 0) ? MUL_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'((DIV_CYCLES > 0) ? DIV_CYCLES - 1 : 0);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(4'd0);
  localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(4'd1);
  localparam logic [ALU_W-1:0] ALU_OR   = ALU_W'(4'd2);
  localparam logic [ALU_W-1:0] ALU_AND  = ALU_W'(4'd3);
  localparam logic [ALU_W-1:0] ALU_SLT  = ALU_W'(4'd4);
  localparam logic [ALU_W-1:0] ALU_SLL  = ALU_W'(4'd5);
  localparam logic [ALU_W-1:0] ALU_SRL  = ALU_W'(4'd6);
  localparam logic [ALU_W-1:0] ALU_BGE  = ALU_W'(4'd7);
  localparam logic [ALU_W-1:0] ALU_XOR  = ALU_W'(4'd8);
  localparam logic [ALU_W-1:0] ALU_SLTU = ALU_W'(4'd9);
  localparam logic [ALU_W-1:0] ALU_SRA  = ALU_W'(4'd10);
  localparam logic [ALU_W-1:0] ALU_ILL  = '1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic [ALU_W-1:0] alu;
    logic             regwrite;
    logic             memtoreg;
    logic             alusrc;
    logic             memread;
    logic             memwrite;
    logic             branch;
    logic             branch_ne;
    logic             jump;
    logic             m_op;
    logic             sys;
    logic             illegal;
  } ctrl_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q;
  ctrl_t            ctrl_q;
  ctrl_t            ctrl_d;
  logic [17:0]      fld_q;
  logic [17:0]      fld_d;
  logic             ill;
  logic [ALU_W-1:0] alu_sel;
  logic             hold_d;
  logic [CNT_W-1:0] cnt_d;
  logic             in_ready;
  logic             accept;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];
  assign fld_d  = {bus.instr[11:7], bus.instr[19:15], bus.instr[24:20], bus.instr[14:12]};

  // alt selects the SUB/SRA variant; it is only a legal encoding for funct3 0 and 5.
  function automatic logic [ALU_W-1:0] arith_alu(input logic [2:0] f3, input logic alt);
    logic [ALU_W-1:0] r;
    case (f3)
      3'd0:    r = alt ? ALU_SUB : ALU_ADD;
      3'd1:    r = alt ? ALU_ILL : ALU_SLL;
      3'd2:    r = alt ? ALU_ILL : ALU_SLT;
      3'd3:    r = alt ? ALU_ILL : ALU_SLTU;
      3'd4:    r = alt ? ALU_ILL : ALU_XOR;
      3'd5:    r = alt ? ALU_SRA : ALU_SRL;
      3'd6:    r = alt ? ALU_ILL : ALU_OR;
      default: r = alt ? ALU_ILL : ALU_AND;
    endcase
    return r;
  endfunction

  always_comb begin
    ctrl_d  = '0;
    ill     = 1'b0;
    alu_sel = ALU_ADD;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'h01) begin
          if (M_EN != 0) begin
            ctrl_d.m_op     = 1'b1;
            ctrl_d.regwrite = 1'b1;
            ctrl_d.alu      = ALU_W'(funct3);
          end else begin
            ill = 1'b1;
          end
        end else if (funct7 == 7'h00 || funct7 == 7'h20) begin
          alu_sel = arith_alu(funct3, funct7[5]);
          if (alu_sel == ALU_ILL) begin
            ill = 1'b1;
          end else begin
            ctrl_d.regwrite = 1'b1;
            ctrl_d.alu      = alu_sel;
          end
        end else begin
          ill = 1'b1;
        end
      end
      OP_I_ALU: begin
        ctrl_d.regwrite = 1'b1;
        ctrl_d.alusrc   = 1'b1;
        ctrl_d.alu      = arith_alu(funct3, (funct3 == 3'd5) && bus.instr[30]);
      end
      OP_LOAD: begin
        ctrl_d.regwrite = 1'b1;
        ctrl_d.memtoreg = 1'b1;
        ctrl_d.alusrc   = 1'b1;
        ctrl_d.memread  = 1'b1;
      end
      OP_STORE: begin
        ctrl_d.alusrc   = 1'b1;
        ctrl_d.memwrite = 1'b1;
      end
      OP_BRANCH: begin
        case (funct3)
          3'd0:    begin ctrl_d.branch    = 1'b1; ctrl_d.alu = ALU_SUB;  end
          3'd1:    begin ctrl_d.branch_ne = 1'b1; ctrl_d.alu = ALU_SUB;  end
          3'd4:    begin ctrl_d.branch    = 1'b1; ctrl_d.alu = ALU_SLT;  end
          3'd5:    begin ctrl_d.branch    = 1'b1; ctrl_d.alu = ALU_BGE;  end
          3'd6:    begin ctrl_d.branch    = 1'b1; ctrl_d.alu = ALU_SLTU; end
          3'd7:    begin ctrl_d.branch    = 1'b1; ctrl_d.alu = ALU_BGE;  end
          default: ill = 1'b1;
        endcase
      end
      OP_JAL, OP_JALR: begin
        ctrl_d.regwrite = 1'b1;
        ctrl_d.jump     = 1'b1;
        ctrl_d.alusrc   = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        ctrl_d.regwrite = 1'b1;
        ctrl_d.alusrc   = 1'b1;
      end
      OP_SYSTEM: ctrl_d.sys = 1'b1;
      default:   ill = 1'b1;
    endcase
    if (ill) begin
      ctrl_d         = '0;
      ctrl_d.illegal = 1'b1;
      ctrl_d.alu     = ALU_ILL;
    end
  end

  assign hold_d   = ctrl_d.m_op && (funct3[2] ? (DIV_CYCLES > 0) : (MUL_CYCLES > 0));
  assign cnt_d    = funct3[2] ? DIV_LD : MUL_LD;
  // Gated by rst_n so nothing is offered upstream while reset is asserted.
  assign in_ready = rst_n && (state_q == IDLE) && (!out_valid_q || bus.out_ready) && !bus.flush;
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      fld_q       <= '0;
    end else if (bus.flush) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            ctrl_q <= ctrl_d;
            fld_q  <= fld_d;
            if (hold_d) begin
              state_q     <= HOLD;
              cnt_q       <= cnt_d;
              out_valid_q <= 1'b0;
            end else begin
              out_valid_q <= 1'b1;
            end
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_ctrl  = ctrl_q.alu;
  assign bus.regwrite  = ctrl_q.regwrite;
  assign bus.memtoreg  = ctrl_q.memtoreg;
  assign bus.alusrc    = ctrl_q.alusrc;
  assign bus.memread   = ctrl_q.memread;
  assign bus.memwrite  = ctrl_q.memwrite;
  assign bus.branch    = ctrl_q.branch;
  assign bus.branch_ne = ctrl_q.branch_ne;
  assign bus.jump      = ctrl_q.jump;
  assign bus.m_op      = ctrl_q.m_op;
  assign bus.sys       = ctrl_q.sys;
  assign bus.illegal   = ctrl_q.illegal;
  assign bus.rd        = fld_q[17:13];
  assign bus.rs1       = fld_q[12:8];
  assign bus.rs2       = fld_q[7:3];
  assign bus.funct3    = fld_q[2:0];

endmodule
